// File: rtl/audacq_fifo_ctrl.sv
// ============================================================================
// audacq_fifo_ctrl : bus slave sequencing the audio acquisition core and
//                    buffering its 24-bit samples in a FIFO (DR/CR/SR regs).
// Optional feature macro: AUDACQ_FIFO_IRQ_EN (level/overflow interrupt).
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef ADA_VA_WIDTH
`define ADA_VA_WIDTH 16
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module audacq_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [`ADA_VA_WIDTH-1:0]  addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault,
  output logic                      acq_rstn,
  input  logic                      arrive,
  input  logic [23:0]               sample,
  output logic                      irq
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_LVL_W = DEPTH_LOG2 + 1;
  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(c_DEPTH);
  localparam logic [`ADA_VA_WIDTH-1:0] c_ADDR_DR = `ADA_VA_WIDTH'(0);
  localparam logic [`ADA_VA_WIDTH-1:0] c_ADDR_CR = `ADA_VA_WIDTH'(4);
  localparam logic [`ADA_VA_WIDTH-1:0] c_ADDR_SR = `ADA_VA_WIDTH'(8);

  logic [23:0]           r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [c_LVL_W-1:0]    r_level;
  logic                  r_en;
  logic [7:0]            r_thr;
  logic                  r_ovr;
  logic                  r_resp;
  logic [31:0]           r_rdata;
  logic                  r_irq;

  logic        w_is_dr, w_is_cr, w_is_sr;
  logic        w_invalid, w_accept, w_rd, w_wr;
  logic        w_empty, w_full, w_clr, w_pop;
  logic        w_arr_en, w_push, w_ovr_set, w_irqp;
  logic [7:0]  w_level8;
  logic [31:0] w_rd_word;
  logic        w_unused_wdata;

  assign w_is_dr   = (addr == c_ADDR_DR);
  assign w_is_cr   = (addr == c_ADDR_CR);
  assign w_is_sr   = (addr == c_ADDR_SR);
  assign w_invalid = !(w_is_dr || w_is_cr || w_is_sr) || (acc != `BUS_ACC_4B) ||
                     (w_rb && !w_is_cr);
  assign w_accept  = req && !w_invalid;
  assign w_rd      = w_accept && !w_rb;
  assign w_wr      = w_accept && w_rb;
  assign fault     = req && w_invalid;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_FULL_LVL);
  assign w_level8  = 8'(r_level);
  assign w_clr     = w_wr && wdata[1];
  assign w_pop     = w_rd && w_is_dr && !w_empty;

  // A clear in flight discards any arriving sample without counting it as overflow.
  assign w_arr_en  = arrive && r_en && !w_clr;
  assign w_push    = w_arr_en && (!w_full || w_pop);
  assign w_ovr_set = w_arr_en && w_full && !w_pop;

`ifdef AUDACQ_FIFO_IRQ_EN
  assign w_irqp = (r_en && (r_thr != 8'd0) && (w_level8 >= r_thr)) || r_ovr;
`else
  assign w_irqp = 1'b0;
`endif

  always_comb begin
    w_rd_word = 32'h0;
    if (w_is_dr) begin
      if (!w_empty) w_rd_word = {1'b1, 7'b0, r_mem[r_rptr]};
    end else if (w_is_cr) begin
      w_rd_word = {16'b0, r_thr, 7'b0, r_en};
    end else if (w_is_sr) begin
      w_rd_word = {20'b0, w_irqp, r_ovr, w_full, w_empty, w_level8};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_en    <= 1'b0;
      r_thr   <= 8'd0;
      r_ovr   <= 1'b0;
      r_resp  <= 1'b0;
      r_rdata <= 32'h0;
      r_irq   <= 1'b0;
    end else begin
      r_resp <= w_accept;
      r_irq  <= w_irqp;
      if (w_rd) r_rdata <= w_rd_word;
      if (w_wr) begin
        r_en  <= wdata[0];
        r_thr <= wdata[15:8];
      end
      if (w_clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
        if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
        if (w_push && !w_pop)      r_level <= r_level + c_LVL_W'(1);
        else if (w_pop && !w_push) r_level <= r_level - c_LVL_W'(1);
      end
      // A fresh overflow wins over the read-to-clear so it is never lost.
      if (w_ovr_set)             r_ovr <= 1'b1;
      else if (w_rd && w_is_sr)  r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= sample;
  end

  assign w_unused_wdata = ^{wdata[`BUS_WIDTH-1:16], wdata[7:2]};

  assign rdata    = r_rdata;
  assign resp     = r_resp;
  assign acq_rstn = r_en;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_audacq_fifo_ctrl.sv
// ============================================================================
// tb_audacq_fifo_ctrl : directed + randomized bench with a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef ADA_VA_WIDTH
`define ADA_VA_WIDTH 16
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module tb_audacq_fifo_ctrl;

  localparam int DEPTH = 16;
`ifdef AUDACQ_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [1:0] ACC4 = `BUS_ACC_4B;

  logic                      clk;
  logic                      rstn;
  logic [`ADA_VA_WIDTH-1:0]  addr;
  logic                      w_rb;
  logic [`BUS_ACC_WIDTH-1:0] acc;
  logic [`BUS_WIDTH-1:0]     rdata;
  logic [`BUS_WIDTH-1:0]     wdata;
  logic                      req;
  logic                      resp;
  logic                      fault;
  logic                      acq_rstn;
  logic                      arrive;
  logic [23:0]               sample;
  logic                      irq;

  audacq_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .w_rb(w_rb), .acc(acc),
    .rdata(rdata), .wdata(wdata), .req(req), .resp(resp), .fault(fault),
    .acq_rstn(acq_rstn), .arrive(arrive), .sample(sample), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue, registers as plain variables.
  logic [23:0] q[$];
  bit          m_en;
  logic [7:0]  m_thr;
  bit          m_ovr;
  logic [31:0] m_rdata;
  bit          e_resp, e_fault, e_irq;
  logic [35:0] e_vec, o_vec;
  logic        o_fault;

  function automatic bit m_irqp();
    if (!IRQ_ON) return 1'b0;
    return (m_en && m_thr != 0 && q.size() >= int'(m_thr)) || m_ovr;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_thr = 0; m_ovr = 0; m_rdata = 0;
  endtask

  task automatic model(input bit rq, input bit wr, input int a, input logic [1:0] ac,
                       input logic [31:0] wd, input bit arr, input logic [23:0] smp);
    bit inval, ok, clr, pop, ovr_set, irqp_now;
    int lvl;
    inval    = !(a == 0 || a == 4 || a == 8) || ac != ACC4 || (wr && a != 4);
    ok       = rq && !inval;
    e_fault  = rq && inval;
    e_resp   = ok;
    lvl      = q.size();
    irqp_now = m_irqp();
    e_irq    = irqp_now;
    ovr_set  = 0;
    if (ok && !wr) begin
      case (a)
        0: m_rdata = (lvl > 0) ? {8'h80, q[0]} : 32'h0;
        4: m_rdata = {16'h0, m_thr, 7'h0, m_en};
        default: m_rdata = {20'h0, irqp_now, m_ovr, lvl == DEPTH, lvl == 0, 8'(lvl)};
      endcase
    end
    clr = ok && wr && wd[1];
    pop = ok && !wr && a == 0 && lvl > 0;
    if (pop) void'(q.pop_front());
    if (arr && m_en && !clr) begin
      if (lvl < DEPTH || pop) q.push_back(smp);
      else ovr_set = 1;
    end
    if (clr) q.delete();
    if (ok && !wr && a == 8) m_ovr = 0;
    if (ovr_set) m_ovr = 1;
    if (ok && wr) begin
      m_en  = wd[0];
      m_thr = wd[15:8];
    end
    e_vec = {e_resp, e_fault, m_en, e_irq, m_rdata};
  endtask

  // Drives one clock cycle of bus/core stimulus starting just after a rising edge.
  task automatic do_cycle(input bit rq, input bit wr, input int a, input logic [1:0] ac,
                          input logic [31:0] wd, input bit arr, input logic [23:0] smp);
    req = rq; w_rb = wr; addr = `ADA_VA_WIDTH'(a); acc = ac;
    wdata = wd; arrive = arr; sample = smp;
    model(rq, wr, a, ac, wd, arr, smp);
    #1 o_fault = fault;
    @(posedge clk);
    #1 o_vec = {resp, o_fault, acq_rstn, irq, rdata};
  endtask

  task automatic rd(input int a);
    do_cycle(1, 0, a, ACC4, 32'h0, 0, 24'h0);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    do_cycle(1, 1, a, ACC4, d, 0, 24'h0);
  endtask
  task automatic push(input logic [23:0] s);
    do_cycle(0, 0, 0, ACC4, 32'h0, 1, s);
  endtask
  task automatic idle();
    do_cycle(0, 0, 0, ACC4, 32'h0, 0, 24'h0);
  endtask

  task automatic test_reset();
    rstn = 0; req = 0; w_rb = 0; addr = '0; acc = ACC4; wdata = '0; arrive = 0; sample = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    checks++;
    if ({resp, acq_rstn, irq, rdata} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {resp, acq_rstn, irq, rdata}, 35'h0);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0000_0100) begin
      errors++;
      $display("FAIL reset_sr: got %h expected %h", o_vec, e_vec);
    end
  endtask

  task automatic test_basic();
    logic [23:0] s [3];
    logic [31:0] exp_dr [4];
    s = '{24'h123456, 24'h00ABCD, 24'hFFFFFF};
    exp_dr = '{32'h80123456, 32'h8000ABCD, 32'h80FFFFFF, 32'h0};
    wr(4, 32'h1);
    for (int i = 0; i < 3; i++) begin
      push(s[i]);
      checks++;
      if (o_vec !== e_vec) begin
        errors++; $display("FAIL basic_push %0d: got %h expected %h", i, o_vec, e_vec);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd(0);
      checks++;
      if (o_vec !== e_vec || rdata !== exp_dr[i]) begin
        errors++; $display("FAIL basic_dr %0d: got %h expected %h", i, rdata, exp_dr[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] s [17];
    wr(4, 32'h3);
    for (int i = 0; i < 17; i++) begin
      s[i] = 24'($urandom);
      push(s[i]);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== (IRQ_ON ? 32'h0000_0E10 : 32'h0000_0610)) begin
      errors++; $display("FAIL ovf_sr1: got %h expected %h", o_vec, e_vec);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata[10] !== 1'b0) begin
      errors++; $display("FAIL ovf_sr2: got %h expected %h", o_vec, e_vec);
    end
    for (int i = 0; i < 17; i++) begin
      rd(0);
      checks++;
      if (o_vec !== e_vec || rdata !== ((i < 16) ? {8'h80, s[i]} : 32'h0)) begin
        errors++; $display("FAIL ovf_drain %0d: got %h expected %h", i, o_vec, e_vec);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [23:0] first;
    wr(4, 32'h3);
    first = 24'($urandom);
    push(first);
    for (int i = 1; i < 16; i++) push(24'($urandom));
    do_cycle(1, 0, 0, ACC4, 32'h0, 1, 24'h5A5A5A);
    checks++;
    if (o_vec !== e_vec || rdata !== {8'h80, first}) begin
      errors++; $display("FAIL full_pushpop: got %h expected %h", o_vec, e_vec);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0000_0210) begin
      errors++; $display("FAIL full_pushpop_sr: got %h expected %h", rdata, 32'h210);
    end
    wr(4, 32'h3);
    do_cycle(1, 0, 0, ACC4, 32'h0, 1, 24'h777777);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0) begin
      errors++; $display("FAIL empty_pushpop: got %h expected %h", o_vec, e_vec);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0000_0001) begin
      errors++; $display("FAIL empty_pushpop_sr: got %h expected %h", rdata, 32'h1);
    end
  endtask

  task automatic test_invalid();
    do_cycle(1, 0, 0,  2'd1, 32'h0, 0, 24'h0);
    checks++;
    if (o_vec !== e_vec || o_fault !== 1'b1 || resp !== 1'b0) begin
      errors++; $display("FAIL inv_acc2b: got %h expected %h", o_vec, e_vec);
    end
    do_cycle(1, 1, 8,  ACC4, 32'hFFFF_FFFF, 0, 24'h0);
    checks++;
    if (o_vec !== e_vec || o_fault !== 1'b1 || resp !== 1'b0) begin
      errors++; $display("FAIL inv_wr_sr: got %h expected %h", o_vec, e_vec);
    end
    do_cycle(1, 0, 12, ACC4, 32'h0, 0, 24'h0);
    checks++;
    if (o_vec !== e_vec || o_fault !== 1'b1 || resp !== 1'b0) begin
      errors++; $display("FAIL inv_addr_c: got %h expected %h", o_vec, e_vec);
    end
    do_cycle(1, 1, 0,  ACC4, 32'h0, 0, 24'h0);
    checks++;
    if (o_vec !== e_vec || o_fault !== 1'b1) begin
      errors++; $display("FAIL inv_wr_dr: got %h expected %h", o_vec, e_vec);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0000_0001) begin
      errors++; $display("FAIL inv_unchanged: got %h expected %h", rdata, 32'h1);
    end
  endtask

  task automatic test_irq();
    rd(8);
    wr(4, 32'h0000_0403);
    for (int i = 0; i < 4; i++) push(24'(i + 1));
    checks++;
    if (o_vec !== e_vec || irq !== 1'b0) begin
      errors++; $display("FAIL irq_at_level: got %b expected %b", irq, 1'b0);
    end
    idle();
    checks++;
    if (o_vec !== e_vec || irq !== IRQ_ON) begin
      errors++; $display("FAIL irq_rise: got %b expected %b", irq, IRQ_ON);
    end
    rd(0);
    idle();
    checks++;
    if (o_vec !== e_vec || irq !== 1'b0) begin
      errors++; $display("FAIL irq_fall: got %b expected %b", irq, 1'b0);
    end
    push(24'h42);
    idle();
    wr(4, 32'h0000_0403);
    idle();
    checks++;
    if (o_vec !== e_vec || irq !== 1'b0) begin
      errors++; $display("FAIL irq_clr: got %b expected %b", irq, 1'b0);
    end
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata[7:0] !== 8'h0) begin
      errors++; $display("FAIL irq_clr_level: got %h expected %h", rdata[7:0], 8'h0);
    end
  endtask

  task automatic test_back_to_back();
    wr(4, 32'h3);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1, 0, (i % 3 == 2) ? 8 : 0, ACC4, 32'h0, ($urandom_range(0, 3) != 0),
               24'($urandom));
      checks++;
      if (o_vec !== e_vec) begin
        errors++; $display("FAIL b2b %0d: got %h expected %h", i, o_vec, e_vec);
      end
    end
  endtask

  task automatic test_random();
    int r, a;
    logic [31:0] wd;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 30) begin
        do_cycle(1, 0, 0, ACC4, wd, $urandom_range(0, 99) < 60, 24'($urandom));
      end else if (r < 45) begin
        do_cycle(1, 0, 8, ACC4, wd, $urandom_range(0, 99) < 60, 24'($urandom));
      end else if (r < 50) begin
        do_cycle(1, 0, 4, ACC4, wd, $urandom_range(0, 99) < 60, 24'($urandom));
      end else if (r < 57) begin
        wd[0]    = ($urandom_range(0, 9) != 0);
        wd[1]    = ($urandom_range(0, 19) == 0);
        wd[15:8] = 8'($urandom_range(0, 20));
        do_cycle(1, 1, 4, ACC4, wd, $urandom_range(0, 99) < 60, 24'($urandom));
      end else if (r < 62) begin
        a = 2 * $urandom_range(0, 7);
        do_cycle(1, $urandom_range(0, 1) != 0, a, 2'($urandom_range(0, 3)), wd,
                 $urandom_range(0, 99) < 60, 24'($urandom));
      end else begin
        do_cycle(0, 0, 0, ACC4, wd, $urandom_range(0, 99) < 60, 24'($urandom));
      end
      checks++;
      if (o_vec !== e_vec) begin
        errors++; $display("FAIL random %0d: got %h expected %h", i, o_vec, e_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    wr(4, 32'h0000_0203);
    for (int i = 0; i < 5; i++) push(24'($urandom));
    rd(0);
    req = 0; arrive = 1;
    #2 rstn = 0;
    #1;
    model_reset();
    checks++;
    if ({resp, acq_rstn, irq, rdata} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", {resp, acq_rstn, irq, rdata}, 35'h0);
    end
    arrive = 0;
    @(posedge clk);
    #1 rstn = 1;
    rd(8);
    checks++;
    if (o_vec !== e_vec || rdata !== 32'h0000_0100) begin
      errors++; $display("FAIL async_reset_sr: got %h expected %h", rdata, 32'h100);
    end
  endtask

  initial begin
    clk = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_invalid();
    test_irq();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audacq_fifo_ctrl.md
# audacq_fifo_ctrl

Bus-slave controller that sequences the audio acquisition core and buffers its samples. It drives the core's enable/reset, captures every completed 24-bit sample into a FIFO and exposes data, control and status registers on the peripheral bus. It sits between the bus fabric and the acquisition core, replacing direct single-sample polling with buffered reads and an optional level interrupt.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries; legal range 2..7.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- addr  in  `ADA_VA_WIDTH  byte address within the block.
- w_rb  in  1  1 = write, 0 = read.
- acc  in  `BUS_ACC_WIDTH  access size.
- rdata  out  `BUS_WIDTH  read data, valid with resp.
- wdata  in  `BUS_WIDTH  write data.
- req  in  1  access request, single-cycle.
- resp  out  1  access completion, one cycle after an accepted req.
- fault  out  1  combinational; req & invalid access.
- acq_rstn  out  1  synchronous active-low reset/enable to the acquisition core.
- arrive  in  1  single-cycle pulse from the core; a sample is complete.
- sample  in  24  sample value, valid while arrive is high.
- irq  out  1  level interrupt (see Configuration).

## Operation
- Registers, all 4-byte, word-aligned:
  - DR @0x0, RO: accepted read pops one entry; returns {1'b1, 7'b0, sample} if non-empty, else 32'h0 with no pop.
  - CR @0x4, RW: bit0 EN; bit1 CLR (write-1 pulse, reads 0); bits[15:8] THR. Other bits read 0.
  - SR @0x8, RO: bits[7:0] level; bit8 EMPTY; bit9 FULL; bit10 OVR (sticky); bit11 IRQP. An accepted SR read returns current OVR, then clears it.
- Invalid: addr not in {0x0,0x4,0x8}; acc != `BUS_ACC_4B; write to DR or SR. Invalid req asserts fault that cycle, no resp, no side effects.
- acq_rstn = registered CR.EN. EN=0 holds the core in reset and ignores arrive.
- Push: arrive & EN & not full → write sample at wptr, level+1.
- Overflow: arrive & EN & full & no pop in same cycle → sample dropped, OVR set.
- Push+pop same cycle: both performed, level unchanged. When full, the push is accepted. When empty, the read returns empty (bit31=0) and the push is accepted.
- CLR: pointers and level reset to 0 next cycle. A same-cycle arrive is dropped without setting OVR. A same-cycle DR pop returns the head entry. OVR is not cleared by CLR.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. level is DEPTH_LOG2+1 bits, zero-extended into SR[7:0].

## Timing
- Reset values: rdata 0, resp 0, acq_rstn 0, irq 0. FIFO empty, CR 0, OVR 0.
- Accepted req in cycle N: resp=1 and rdata valid in N+1. Write and pop side effects are visible in N+1. rdata holds its value until the next accepted read.
- arrive in cycle N: level and EMPTY/FULL update in N+1; DR can return the sample for a req issued in N+1.
- CR.EN write in N: acq_rstn changes in N+1.
- Back-to-back reqs every cycle are supported; each gets resp one cycle later.
- Async reset mid-operation clears all state immediately. The FIFO contents are lost.

## Configuration
- AUDACQ_FIFO_IRQ_EN defined: IRQP = EN & (THR != 0) & (level >= THR), or OVR. irq = IRQP, registered (one cycle after the causing level or OVR change).
- AUDACQ_FIFO_IRQ_EN undefined: irq tied 0, SR bit11 reads 0, CR.THR still stored and readable.

## Test plan
- Reset, read SR → resp next cycle, rdata=32'h0000_0100 (EMPTY), acq_rstn=0.
- Write CR=32'h1; inject 3 arrive pulses with 24'h123456, 24'h00ABCD, 24'hFFFFFF; read DR ×4 → 32'h80123456, 32'h8000ABCD, 32'h80FFFFFF, 32'h0.
- With DEPTH_LOG2=4, push 17 samples without reads → SR=32'h0000_0610 (level 16, FULL, OVR). Second SR read → OVR=0. The 17th sample is absent from DR.
- When full, pulse arrive in the same cycle as a DR read → the read returns the oldest sample, level stays 16, OVR stays 0. Repeat when empty → DR returns 32'h0 and level=1.
- Read DR with acc=2B, write SR, read addr 0xC → fault=1 in the req cycle, resp=0, FIFO unchanged.
- With AUDACQ_FIFO_IRQ_EN defined: CR=32'h0000_0401 (THR=4), push 4 samples → irq rises one cycle after level hits 4. One DR pop → irq falls. Write CR bit1 → level 0, irq 0.
